// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: clear-sequencer state
// encoding and default sizing constants.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int DATA_W_DEF   = 64;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_DEF = 31;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every array index once after reset or on request,
// emitting a zero-write strobe, and raises ready when the walk completes.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_idx,
    output logic              o_ready
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_ready;

    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_ready_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_idx_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_clr_idx;
        w_ready_nxt = r_ready;
        case (r_state)
            CLEAR: begin
                // clr_req is deliberately ignored here: an in-flight walk is never restarted
                w_idx_nxt = r_clr_idx + IDX_ONE;
                if (r_clr_idx == IDX_LAST) begin
                    w_state_nxt = RUN;
                    w_ready_nxt = 1'b1;
                end
            end
            RUN: begin
                if (i_clr_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                    w_ready_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_idx_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    assign o_clr_we  = (r_state == CLEAR);
    assign o_clr_idx = r_clr_idx;
    assign o_ready   = r_ready;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with optional hardwired zero register, same-cycle
// write-to-read bypass and a hardware clear sequencer.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       clr_req,
    output logic                       ready,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_drop,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ*DATA_W-1:0] rd_data
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_drop;

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_ready;
    logic              w_wr_zero;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_clr_req (clr_req),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx),
        .o_ready   (w_ready)
    );

    assign w_wr_zero = (ZERO_EN != 0) && (wr_addr == ZERO_IDX);

    // Clear writes take the array port ahead of user writes; the two never
    // coincide because user writes require ready, which is low during a clear.
    always_ff @(posedge Clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_ready && wr_en && !w_wr_zero) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= wr_en && !w_ready;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = '0;
            if (!w_ready) begin
                w_data = '0;
            end else if ((ZERO_EN != 0) && (w_addr == ZERO_IDX)) begin
                w_data = '0;
            end else if (wr_en && (wr_addr == w_addr)) begin
                w_data = wr_data;
            end else begin
                w_data = r_mem[w_addr];
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = w_data;
    end

    assign ready   = w_ready;
    assign wr_drop = r_wr_drop;

endmodule
